// File: rtl/jtag_scan_master.sv
// Host-side JTAG sequencer: walks the TAP from Run-Test/Idle through a reset,
// IR scan, DR scan or idle clocking, and returns the captured TDO bits.
module jtag_scan_master #(
  parameter int CLK_DIV = 2,
  parameter int MAX_LEN = 32
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [1:0]         cmd_op_i,
  input  logic [4:0]         cmd_len_i,
  input  logic [MAX_LEN-1:0] cmd_data_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [MAX_LEN-1:0] rsp_data_o,
  output logic               busy_o,
  output logic               tck_pad_o,
  output logic               tms_pad_o,
  output logic               tdi_pad_o,
  output logic               trst_pad_o,
  input  logic               tdo_pad_i
);

  typedef enum logic [2:0] {S_IDLE, S_TRST, S_PRE, S_SHIFT, S_POST, S_RUN, S_RESP} state_t;

  localparam logic [1:0] OP_RESET = 2'b00;
  localparam logic [1:0] OP_IR    = 2'b01;
  localparam logic [1:0] OP_IDLE  = 2'b11;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  state_t             r_state, w_state_next;
  logic [DIV_W-1:0]   r_div_cnt, w_div_next;
  logic               r_tck, w_tck_next;
  logic               r_tms, w_tms_next;
  logic               r_tdi, w_tdi_next;
  logic               r_trst, w_trst_next;
  logic               r_ready_en, w_ready_next;
  logic [1:0]         r_op, w_op_next;
  logic [4:0]         r_len, w_len_next;
  logic [MAX_LEN-1:0] r_data, w_data_next;
  logic [MAX_LEN-1:0] r_capture, w_capture_next;
  logic [4:0]         r_bit_cnt, w_bit_next;

  logic       w_active, w_tck_state, w_tick, w_rise, w_fall;
  logic [4:0] w_bit_inc;

  // TMS bit for TCK idx of the approach into Shift-IR/DR (or into Run-Test/Idle for RESET).
  function automatic logic f_pre_tms(input logic [1:0] op, input logic [4:0] idx);
    case (op)
      OP_RESET: return idx < 5'd5;
      OP_IR:    return idx < 5'd2;
      default:  return idx == 5'd0;
    endcase
  endfunction

  function automatic logic [4:0] f_pre_last(input logic [1:0] op);
    case (op)
      OP_RESET: return 5'd5;
      OP_IR:    return 5'd3;
      default:  return 5'd2;
    endcase
  endfunction

  assign w_active    = r_state inside {S_TRST, S_PRE, S_SHIFT, S_POST, S_RUN};
  assign w_tck_state = r_state inside {S_PRE, S_SHIFT, S_POST, S_RUN};
  assign w_tick      = w_active && (r_div_cnt == DIV_LAST);
  assign w_rise      = w_tick && w_tck_state && !r_tck;
  assign w_fall      = w_tick && w_tck_state && r_tck;
  assign w_bit_inc   = r_bit_cnt + 5'd1;

  // NOTE: every signal driven here gets its hold value first, so no path can infer a latch.
  always_comb begin
    w_state_next   = r_state;
    w_div_next     = r_div_cnt;
    w_tck_next     = r_tck;
    w_tms_next     = r_tms;
    w_tdi_next     = r_tdi;
    w_trst_next    = r_trst;
    w_ready_next   = r_ready_en | ~r_trst;
    w_op_next      = r_op;
    w_len_next     = r_len;
    w_data_next    = r_data;
    w_capture_next = r_capture;
    w_bit_next     = r_bit_cnt;

    if (w_active) w_div_next = w_tick ? '0 : r_div_cnt + DIV_W'(1);
    if (w_tick && w_tck_state) w_tck_next = ~r_tck;

    case (r_state)
      S_IDLE: begin
        w_trst_next = 1'b0;
        if (cmd_valid_i && cmd_ready_o) begin
          w_op_next      = cmd_op_i;
          w_len_next     = cmd_len_i;
          w_data_next    = cmd_data_i;
          w_capture_next = '0;
          w_bit_next     = '0;
          w_div_next     = '0;
          w_tdi_next     = 1'b0;
          w_tms_next     = (cmd_op_i != OP_IDLE);
          case (cmd_op_i)
            OP_RESET: begin
              w_state_next = S_TRST;
              w_trst_next  = 1'b1;
            end
            OP_IDLE: w_state_next = S_RUN;
            default: w_state_next = S_PRE;
          endcase
        end
      end
      // TRST spans two divider half-periods with TCK parked low.
      S_TRST: begin
        if (w_tick) begin
          if (r_bit_cnt == 5'd1) begin
            w_state_next = S_PRE;
            w_bit_next   = '0;
            w_trst_next  = 1'b0;
            w_tms_next   = 1'b1;
          end else begin
            w_bit_next = 5'd1;
          end
        end
      end
      S_PRE: begin
        if (w_fall) begin
          if (r_bit_cnt == f_pre_last(r_op)) begin
            w_bit_next = '0;
            if (r_op == OP_RESET) begin
              w_state_next = S_RESP;
              w_tms_next   = 1'b0;
            end else begin
              w_state_next = S_SHIFT;
              w_tms_next   = (r_len == 5'd0);
              w_tdi_next   = r_data[0];
            end
          end else begin
            w_bit_next = w_bit_inc;
            w_tms_next = f_pre_tms(r_op, w_bit_inc);
          end
        end
      end
      S_SHIFT: begin
        if (w_rise) w_capture_next[r_bit_cnt] = tdo_pad_i;
        if (w_fall) begin
          if (r_bit_cnt == r_len) begin
            w_state_next = S_POST;
            w_bit_next   = '0;
            w_tms_next   = 1'b1;
            w_tdi_next   = 1'b0;
          end else begin
            w_bit_next = w_bit_inc;
            w_tms_next = (w_bit_inc == r_len);
            w_tdi_next = r_data[w_bit_inc];
          end
        end
      end
      S_POST: begin
        if (w_fall) begin
          if (r_bit_cnt == 5'd1) begin
            w_state_next = S_RESP;
          end else begin
            w_bit_next = 5'd1;
            w_tms_next = 1'b0;
          end
        end
      end
      S_RUN: begin
        if (w_fall) begin
          if (r_bit_cnt == r_len) w_state_next = S_RESP;
          else                    w_bit_next   = w_bit_inc;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= S_IDLE;
      r_div_cnt  <= '0;
      r_tck      <= 1'b0;
      r_tms      <= 1'b1;
      r_tdi      <= 1'b0;
      r_trst     <= 1'b1;
      r_ready_en <= 1'b0;
      r_op       <= OP_RESET;
      r_len      <= '0;
      r_data     <= '0;
      r_capture  <= '0;
      r_bit_cnt  <= '0;
    end else begin
      r_state    <= w_state_next;
      r_div_cnt  <= w_div_next;
      r_tck      <= w_tck_next;
      r_tms      <= w_tms_next;
      r_tdi      <= w_tdi_next;
      r_trst     <= w_trst_next;
      r_ready_en <= w_ready_next;
      r_op       <= w_op_next;
      r_len      <= w_len_next;
      r_data     <= w_data_next;
      r_capture  <= w_capture_next;
      r_bit_cnt  <= w_bit_next;
    end
  end

  // Capture is cleared on acceptance and only scans write it, so RESET/IDLE report 0.
  assign cmd_ready_o = (r_state == S_IDLE) && r_ready_en;
  assign rsp_valid_o = (r_state == S_RESP);
  assign rsp_data_o  = r_capture;
  assign busy_o      = (r_state != S_IDLE);
  assign tck_pad_o   = r_tck;
  assign tms_pad_o   = r_tms;
  assign tdi_pad_o   = r_tdi;
  assign trst_pad_o  = r_trst;

endmodule

// File: tb/tb_jtag_scan_master.sv
// Bench for jtag_scan_master: a behavioural TAP answers on the pads, a scoreboard
// queue holds the expected response of each command and a monitor checks it.
module tb_jtag_scan_master;

  localparam int CLK_DIV = 2;
  localparam int MAX_LEN = 32;
  localparam logic [3:0]  IR_IDCODE    = 4'b0001;
  localparam logic [31:0] IDCODE_VALUE = 32'h1BA0_1477;
  localparam logic [1:0]  OP_RESET = 2'b00, OP_IR = 2'b01, OP_DR = 2'b10, OP_IDLE = 2'b11;

  logic               clk_i = 1'b0;
  logic               rst_n_i = 1'b1;
  logic               cmd_valid_i = 1'b0;
  logic               cmd_ready_o;
  logic [1:0]         cmd_op_i = '0;
  logic [4:0]         cmd_len_i = '0;
  logic [MAX_LEN-1:0] cmd_data_i = '0;
  logic               rsp_valid_o;
  logic               rsp_ready_i = 1'b1;
  logic [MAX_LEN-1:0] rsp_data_o;
  logic               busy_o;
  logic               tck_pad_o, tms_pad_o, tdi_pad_o, trst_pad_o;
  logic               tdo_pad_i = 1'b0;

  jtag_scan_master #(.CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_op_i(cmd_op_i), .cmd_len_i(cmd_len_i), .cmd_data_i(cmd_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
    .busy_o(busy_o), .tck_pad_o(tck_pad_o), .tms_pad_o(tms_pad_o),
    .tdi_pad_o(tdi_pad_o), .trst_pad_o(trst_pad_o), .tdo_pad_i(tdo_pad_i)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- Behavioural TAP ----------------
  typedef enum logic [3:0] {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PDR, EX2DR, UPDR,
                            SELIR, CAPIR, SHIR, EX1IR, PIR, EX2IR, UPIR} tap_t;
  tap_t        tap = TLR;
  logic [3:0]  ir = IR_IDCODE;
  logic [3:0]  ir_sr = '0;
  logic [31:0] dr_sr = '0;
  logic        byp = 1'b0;

  function automatic tap_t tap_next(input tap_t s, input logic tms);
    case (s)
      TLR:   return tms ? TLR   : RTI;
      RTI:   return tms ? SELDR : RTI;
      SELDR: return tms ? SELIR : CAPDR;
      CAPDR: return tms ? EX1DR : SHDR;
      SHDR:  return tms ? EX1DR : SHDR;
      EX1DR: return tms ? UPDR  : PDR;
      PDR:   return tms ? EX2DR : PDR;
      EX2DR: return tms ? UPDR  : SHDR;
      UPDR:  return tms ? SELDR : RTI;
      SELIR: return tms ? TLR   : CAPIR;
      CAPIR: return tms ? EX1IR : SHIR;
      SHIR:  return tms ? EX1IR : SHIR;
      EX1IR: return tms ? UPIR  : PIR;
      PIR:   return tms ? EX2IR : PIR;
      EX2IR: return tms ? UPIR  : SHIR;
      default: return tms ? SELDR : RTI;
    endcase
  endfunction

  always @(posedge tck_pad_o or posedge trst_pad_o) begin
    if (trst_pad_o) begin
      tap <= TLR;
      ir  <= IR_IDCODE;
    end else begin
      case (tap)
        TLR:   ir <= IR_IDCODE;
        CAPDR: if (ir == IR_IDCODE) dr_sr <= IDCODE_VALUE; else byp <= 1'b0;
        SHDR:  if (ir == IR_IDCODE) dr_sr <= {tdi_pad_o, dr_sr[31:1]}; else byp <= tdi_pad_o;
        CAPIR: ir_sr <= 4'b0101;
        SHIR:  ir_sr <= {tdi_pad_o, ir_sr[3:1]};
        UPIR:  ir <= ir_sr;
        default: ;
      endcase
      tap <= tap_next(tap, tms_pad_o);
    end
  end

  always @(negedge tck_pad_o) begin
    case (tap)
      SHDR:    tdo_pad_i <= (ir == IR_IDCODE) ? dr_sr[0] : byp;
      SHIR:    tdo_pad_i <= ir_sr[0];
      default: tdo_pad_i <= 1'b0;
    endcase
  end

  // ---------------- Pad recorders ----------------
  int          n_tck, n_shift, n_trst, tdi_bad;
  int          tck_idle_bad = 0;
  logic [63:0] tms_rec;
  logic [31:0] tdi_rec;

  always @(posedge tck_pad_o) begin
    n_tck++;
    tms_rec = {tms_rec[62:0], tms_pad_o};
    if (tap == SHDR || tap == SHIR) begin
      if (n_shift < 32) tdi_rec[n_shift] = tdi_pad_o;
      n_shift++;
    end else if (tdi_pad_o) begin
      tdi_bad++;
    end
  end

  always @(posedge clk_i) if (rst_n_i && trst_pad_o) n_trst++;
  always @(negedge clk_i) if (rst_n_i && tck_pad_o && !busy_o) tck_idle_bad++;

  // ---------------- Scoreboard + monitor ----------------
  typedef struct {
    string       name;
    logic [31:0] data;
    int          ntck;
    logic [63:0] tms;
    logic [31:0] tdi;
    int          ntrst;
  } exp_t;

  exp_t sb[$];
  int   n_rsp = 0;

  always @(negedge clk_i) begin
    if (rst_n_i && rsp_valid_o && rsp_ready_i) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", 64'(rsp_data_o), 64'hDEAD);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_data"},  64'(rsp_data_o), 64'(e.data));
        check({e.name, "_ntck"},  64'(n_tck),      64'(e.ntck));
        check({e.name, "_tms"},   tms_rec,         e.tms);
        check({e.name, "_tdi"},   64'(tdi_rec),    64'(e.tdi));
        check({e.name, "_trst"},  64'(n_trst),     64'(e.ntrst));
        check({e.name, "_tdi0"},  64'(tdi_bad),    64'd0);
        check({e.name, "_tapRTI"}, 64'(tap),       64'(RTI));
      end
      n_rsp++;
    end
  end

  // ---------------- Stimulus ----------------
  task automatic clear_rec();
    n_tck = 0; n_shift = 0; n_trst = 0; tdi_bad = 0; tms_rec = '0; tdi_rec = '0;
  endtask

  task automatic issue(input string name, input logic [1:0] op, input logic [4:0] len,
                       input logic [31:0] data);
    bit acc = 0;
    cmd_op_i = op; cmd_len_i = len; cmd_data_i = data; cmd_valid_i = 1'b1;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk_i);
      if (cmd_ready_o) acc = 1;
    end
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0;
    if (!acc) check({name, "_accept"}, 64'(acc), 64'd1);
  endtask

  task automatic send(input string name, input logic [1:0] op, input logic [4:0] len,
                      input logic [31:0] data, input logic [31:0] e_data,
                      input int e_ntck, input logic [63:0] e_tms);
    exp_t        e;
    logic [63:0] mask;
    mask    = (64'd1 << (int'(len) + 1)) - 64'd1;
    e.name  = name;
    e.data  = e_data;
    e.ntck  = e_ntck;
    e.tms   = e_tms;
    e.tdi   = (op == OP_IR || op == OP_DR) ? data & mask[31:0] : 32'd0;
    e.ntrst = (op == OP_RESET) ? 4 : 0;
    clear_rec();
    sb.push_back(e);
    issue(name, op, len, data);
  endtask

  task automatic wait_rsp(input string name, input int target);
    bit done = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(posedge clk_i); #1;
      if (n_rsp >= target) done = 1;
    end
    check({name, "_rsp_seen"}, 64'(done), 64'd1);
    check({name, "_ready_after"}, {62'd0, cmd_ready_o, busy_o}, 64'b10);
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_pads"}, {60'd0, tck_pad_o, tms_pad_o, tdi_pad_o, trst_pad_o}, 64'b0101);
    check({name, "_ctl"},  {61'd0, cmd_ready_o, rsp_valid_o, busy_o}, 64'd0);
    check({name, "_rspd"}, 64'(rsp_data_o), 64'd0);
  endtask

  task automatic release_reset(input string name);
    @(negedge clk_i); rst_n_i = 1'b1;
    @(posedge clk_i); #1;
    check({name, "_rel1"}, {62'd0, trst_pad_o, cmd_ready_o}, 64'b00);
    @(posedge clk_i); #1;
    check({name, "_rel2"}, 64'(cmd_ready_o), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          bad;
    logic [31:0] held;
    bit          seen;

    #3 rst_n_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 check_reset_values("por");
    release_reset("por");

    // DR scan interrupted by reset in the middle of SHIFT: no response may appear.
    clear_rec();
    issue("abort_dr", OP_DR, 5'd31, 32'hFFFF_FFFF);
    repeat (40) @(posedge clk_i);
    #2 check("abort_busy", 64'(busy_o), 64'd1);
    rst_n_i = 1'b0;
    #1 check_reset_values("abort");
    repeat (3) @(posedge clk_i);
    check("abort_no_rsp", 64'(n_rsp), 64'd0);
    release_reset("abort");

    send("reset", OP_RESET, 5'd5, 32'hFFFF_FFFF, 32'd0, 6, 64'b111110);
    wait_rsp("reset", 1);

    send("idcode", OP_DR, 5'd31, 32'd0, IDCODE_VALUE, 37, {3'b100, 31'd0, 1'b1, 2'b10});
    wait_rsp("idcode", 2);

    send("ir_byp", OP_IR, 5'd3, 32'hF, 32'h5, 10, 64'b11_0000_0110);
    wait_rsp("ir_byp", 3);

    send("dr_a5", OP_DR, 5'd7, 32'hA5, 32'h4A, 13, {3'b100, 7'd0, 1'b1, 2'b10});
    wait_rsp("dr_a5", 4);

    // Response held back: outputs frozen, no new command taken, TCK parked low.
    rsp_ready_i = 1'b0;
    send("hold", OP_DR, 5'd7, 32'h3C, 32'h78, 13, {3'b100, 7'd0, 1'b1, 2'b10});
    seen = 0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk_i);
      if (rsp_valid_o) seen = 1;
    end
    check("hold_valid", 64'(seen), 64'd1);
    held = rsp_data_o;
    check("hold_data", 64'(held), 64'h78);
    cmd_op_i = OP_IDLE; cmd_len_i = 5'd3; cmd_valid_i = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (!rsp_valid_o || rsp_data_o !== held || cmd_ready_o || tck_pad_o) bad++;
    end
    cmd_valid_i = 1'b0;
    check("hold_stable", 64'(bad), 64'd0);
    @(posedge clk_i); #1 rsp_ready_i = 1'b1;
    wait_rsp("hold", 5);

    send("idle1", OP_IDLE, 5'd0, 32'hFFFF_FFFF, 32'd0, 1, 64'b0);
    wait_rsp("idle1", 6);

    send("ir_len1", OP_IR, 5'd0, 32'h1, 32'h1, 7, 64'b1100110);
    wait_rsp("ir_len1", 7);

    send("dr_len1", OP_DR, 5'd0, 32'h1, 32'h0, 6, 64'b100110);
    wait_rsp("dr_len1", 8);

    repeat (5) @(posedge clk_i);
    check("sb_empty", 64'(sb.size()), 64'd0);
    check("tck_low_idle", 64'(tck_idle_bad), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
